fft_amp_calc: RTL
=================

// Module: fft_amp_calc
// PURPOSE
//  Upstream neighbour of the fault detector. Takes the complex FFT output stream
//  (re/im per bin, possibly gapped) and computes the squared magnitude re^2+im^2.
//  It keeps only bins 0..N/2-1 and replays them as one gap-free burst on
//  amp_o/amp_vaild_o. The fault detector derives bin index from contiguous valid.
// PARAMETERS
//  NUMBER_OF_DATA  4096  FFT length N (power of 2); N/2 magnitudes emitted per frame
//  DATA_W          16    signed width of fft_re_i / fft_im_i
//  GAP_CYCLES      4     min idle cycles on amp_vaild_o between bursts (>=4)
// PORTS
//  clk_i        in   1         system clock
//  rst_ni       in   1         asynchronous reset, active low
//  fft_re_i     in   DATA_W    real part, signed two's complement
//  fft_im_i     in   DATA_W    imaginary part, signed
//  fft_valid_i  in   1         bin valid; transfer when fft_valid_i && fft_ready_o
//  fft_last_i   in   1         marks bin N-1 of a frame
//  fft_ready_o  out  1         high only in COLLECT
//  amp_o        out  2*DATA_W  unsigned squared magnitude of the current bin
//  amp_vaild_o  out  1         high for exactly N/2 consecutive cycles per good frame
//  frame_err_o  out  1         1-cycle pulse: frame length mismatch, frame dropped
//  busy_o       out  1         high in any state other than COLLECT
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state=COLLECT, bin counter=0, fft_ready_o=1,
//    amp_o=0, amp_vaild_o=0, frame_err_o=0, busy_o=0. Buffer contents undefined.
//  - Arithmetic: 2-stage pipe. S1 registers re*re and im*im (signed, 2*DATA_W).
//    S2 registers their unsigned sum. Max (-2^15)^2*2 = 2^31 fits 32 bits; no saturation.
//  - Buffer: N/2 x 2*DATA_W single-port-write / single-port-read RAM (inferred),
//    written from S2 at address = bin index for bins < N/2. Bins >= N/2 are squared
//    but not written.
//  - bin counter (log2 N bits) increments per accepted transfer.
//  - Gaps in fft_valid_i are allowed; the pipe stalls with its tags.
//  - FSM:
//    COLLECT: accept bins.
//      fft_last_i with counter==N-1 -> FLUSH.
//      fft_last_i with counter!=N-1, or counter==N-1 without last
//        -> pulse frame_err_o, counter=0, stay COLLECT (frame discarded, no burst).
//    FLUSH: 2 cycles, drain the pipe into RAM; fft_ready_o=0 -> DRAIN.
//    DRAIN: read addresses 0..N/2-1, one per cycle; 1-cycle RAM read latency.
//      amp_vaild_o=1 with amp_o=bin k on N/2 consecutive cycles, no bubbles.
//      -> GAP after the last word.
//    GAP: amp_vaild_o=0 for GAP_CYCLES cycles -> COLLECT, counter=0.
//      The gap lets the detector see the falling edge, emit its result, and clear
//      its maxima before the next burst.
//  - Latency: last accepted bin to first amp_vaild_o = 4 cycles
//    (2 flush + 1 state + 1 RAM read).
//  - fft_ready_o=0 during FLUSH/DRAIN/GAP. Upstream must hold its data (back-pressure).
//    Data presented while ready=0 is not consumed.
//  - amp_o holds its last value when amp_vaild_o=0.
//  - Reset mid-burst: amp_vaild_o drops asynchronously. The partial burst is abandoned;
//    the downstream sees a short burst and handles it on its own.
// CONFIGURATION
//  FFT_AMP_DROP_DC_EN defined: bin 0 is written as 32'd0, so DC leakage can never
//    be the maximum. Bin 1 and above are unchanged.
//  Not defined: bin 0 carries its true re^2+im^2. Timing is identical in both builds.
// TESTING
//  1. Reset, N=4096. Stream 4096 bins back-to-back; bin k has re=k[15:0], im=0,
//     last on bin 4095 -> 2048 contiguous amp_vaild_o cycles, amp_o=k*k for k=0..2047;
//     first valid 4 cycles after last transfer.
//  2. Random fft_valid_i gaps (50% duty), re=3, im=-4 on every bin -> burst still
//     2048 gap-free cycles, every amp_o=25; fft_ready_o=0 from FLUSH to end of GAP.
//  3. fft_last_i on bin 100 -> frame_err_o 1-cycle pulse, no amp_vaild_o. The next
//     correct frame produces a normal 2048-cycle burst.
//  4. re=im=-32768 on bin 5 -> amp_o=32'h8000_0000 at burst index 5 (no overflow).
//  5. Two frames back-to-back -> amp_vaild_o low >= GAP_CYCLES(4) cycles between bursts.
//  6. rst_ni low at burst word 1000 -> amp_vaild_o=0 immediately, FSM=COLLECT,
//     fft_ready_o=1. A DC bin of re=1000, im=0 then gives amp_o=1000000 at bin 0
//     without FFT_AMP_DROP_DC_EN, and 0 with it.

Source files
------------

// File: rtl/fft_amp_calc.sv
// Squares each complex FFT bin, buffers bins 0..N/2-1 and replays them as one gap-free burst.
// Optional FFT_AMP_DROP_DC_EN: bin 0 is stored as zero so DC leakage never wins the maximum.
module fft_amp_calc #(
  parameter int NUMBER_OF_DATA = 4096,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic signed [DATA_W-1:0]   fft_re_i,
  input  logic signed [DATA_W-1:0]   fft_im_i,
  input  logic                       fft_valid_i,
  input  logic                       fft_last_i,
  output logic                       fft_ready_o,
  output logic        [2*DATA_W-1:0] amp_o,
  output logic                       amp_vaild_o,
  output logic                       frame_err_o,
  output logic                       busy_o
);

  localparam int CNT_W  = $clog2(NUMBER_OF_DATA);
  localparam int ADDR_W = CNT_W - 1;
  localparam int HALF   = NUMBER_OF_DATA / 2;
  localparam int AMP_W  = 2 * DATA_W;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 2);

  localparam logic [CNT_W-1:0]  LAST_BIN  = CNT_W'(NUMBER_OF_DATA - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HALF - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_CYCLES + 1);

  typedef enum logic [1:0] {COLLECT, FLUSH, DRAIN, GAP} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          bin_cnt;
  logic                      flush_cnt;
  logic [ADDR_W-1:0]         rd_addr;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      rd_vld;

  logic                      accept;
  logic                      advance;

  logic                      s1_vld;
  logic                      s1_keep;
  logic [ADDR_W-1:0]         s1_addr;
  logic signed [AMP_W-1:0]   s1_rr;
  logic signed [AMP_W-1:0]   s1_ii;
  logic                      s2_vld;
  logic [ADDR_W-1:0]         s2_addr;
  logic [AMP_W-1:0]          s2_sum;

  logic [AMP_W-1:0]          wr_data;
  logic                      wr_en;
  logic [AMP_W-1:0]          mem [HALF];
  logic [AMP_W-1:0]          ram_q;

  assign accept  = fft_valid_i && fft_ready_o;
  // The pipe only moves on a transfer, or while FLUSH pushes the tail into the RAM.
  assign advance = accept || (state == FLUSH);
  assign wr_en   = advance && s2_vld;

`ifdef FFT_AMP_DROP_DC_EN
  assign wr_data = (s2_addr == '0) ? '0 : s2_sum;
`else
  assign wr_data = s2_sum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld  <= 1'b0;
      s1_keep <= 1'b0;
      s1_addr <= '0;
      s1_rr   <= '0;
      s1_ii   <= '0;
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_sum  <= '0;
    end else if (advance) begin
      s1_vld  <= accept;
      s1_keep <= ~bin_cnt[CNT_W-1];
      s1_addr <= bin_cnt[ADDR_W-1:0];
      s1_rr   <= fft_re_i * fft_re_i;
      s1_ii   <= fft_im_i * fft_im_i;
      s2_vld  <= s1_vld && s1_keep;
      s2_addr <= s1_addr;
      s2_sum  <= $unsigned(s1_rr) + $unsigned(s1_ii);
    end
  end

  // NOTE: the buffer has no reset so it maps onto block RAM; its contents are rewritten every frame.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[s2_addr] <= wr_data;
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= COLLECT;
      bin_cnt     <= '0;
      flush_cnt   <= 1'b0;
      rd_addr     <= '0;
      gap_cnt     <= '0;
      rd_vld      <= 1'b0;
      fft_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      amp_o       <= '0;
      amp_vaild_o <= 1'b0;
    end else begin
      // NOTE: pulse-type outputs get a default every cycle and are raised only where needed.
      frame_err_o <= 1'b0;
      rd_vld      <= 1'b0;
      amp_vaild_o <= rd_vld;
      if (rd_vld) amp_o <= ram_q;

      case (state)
        COLLECT: begin
          if (accept) begin
            if (fft_last_i && bin_cnt == LAST_BIN) begin
              state       <= FLUSH;
              bin_cnt     <= '0;
              flush_cnt   <= 1'b0;
              fft_ready_o <= 1'b0;
              busy_o      <= 1'b1;
            end else if (fft_last_i || bin_cnt == LAST_BIN) begin
              frame_err_o <= 1'b1;
              bin_cnt     <= '0;
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state   <= DRAIN;
            rd_addr <= '0;
          end
        end
        DRAIN: begin
          rd_vld  <= 1'b1;
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == LAST_ADDR) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          // Two extra cycles cover the words still in the read pipe, so the
          // output itself stays low for GAP_CYCLES before ready returns.
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_END) begin
            state       <= COLLECT;
            bin_cnt     <= '0;
            fft_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
